// File: rtl/softmax_pkg.sv
// Shared constants and helpers for the softmax exp datapath.
// LOG2E_Q is log2(e) in Q1.14; widths below are the stream defaults.
package softmax_pkg;

   localparam int LOG2E_Q     = 23637;
   localparam int LOG2E_FRAC  = 14;

   localparam int IN_W_DEF    = 16;
   localparam int IN_FRAC_DEF = 10;
   localparam int OUT_W_DEF   = 16;
   localparam int R_AW_DEF    = 7;

   function automatic int clog2(input int v);
      int r;
      int n;
      r = 0;
      n = v - 1;
      while (n > 0) begin
         r++;
         n = n >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/exp2_frac_rom.sv
// Fractional power-of-two table: data = round(2^(addr/2^R_AW) * 2^(OUT_W-1)).
// The table is built at elaboration from the defining equation.
module exp2_frac_rom
   import softmax_pkg::*;
#(
   parameter int    R_AW    = R_AW_DEF,
   parameter int    OUT_W   = OUT_W_DEF,
   parameter string R_TABLE = "r_1.dat"
) (
   input  logic             clk,
   input  logic             en,
   input  logic [R_AW-1:0]  addr,
   output logic [OUT_W-1:0] data
);

   localparam int P = 40;

   function automatic logic [127:0] isqrt(input logic [127:0] v);
      logic [127:0] r;
      logic [127:0] b;
      logic [127:0] rem;
      r   = '0;
      rem = v;
      b   = 128'd1 << 126;
      while (b > rem) b = b >> 2;
      while (b != 0) begin
         if (rem >= r + b) begin
            rem = rem - (r + b);
            r   = (r >> 1) + b;
         end else begin
            r = r >> 1;
         end
         b = b >> 2;
      end
      return r;
   endfunction

   // Product of 2^(2^-m) factors, one per set address bit, in Q.40.
   function automatic logic [OUT_W-1:0] entry(input int idx);
      logic [127:0] v;
      logic [127:0] c;
      logic [127:0] res;
      v = 128'd1 << P;
      c = 128'd2 << P;
      for (int m = 1; m <= R_AW; m++) begin
         c = isqrt(c << P);
         if (((idx >> (R_AW - m)) & 1) == 1) v = (v * c) >> P;
      end
      res = ((v << (OUT_W - 1)) + (128'd1 << (P - 1))) >> P;
      return res[OUT_W-1:0];
   endfunction

   logic [OUT_W-1:0] w_rom [2**R_AW];

   generate
      for (genvar g = 0; g < 2**R_AW; g++) begin : g_ent
         localparam logic [OUT_W-1:0] C_VAL = entry(g);
         assign w_rom[g] = C_VAL;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (en) data <= w_rom[addr];
   end

endmodule

// File: rtl/softmax_exp_stream.sv
// Streaming exp(x) for max-subtracted logits: 2^(x*log2e) via a 2^f table and
// a right shift, plus a saturating per-vector sum for the downstream divider.
module softmax_exp_stream
   import softmax_pkg::*;
#(
   parameter int    IN_W    = IN_W_DEF,
   parameter int    IN_FRAC = IN_FRAC_DEF,
   parameter int    OUT_W   = OUT_W_DEF,
   parameter int    R_AW    = R_AW_DEF,
   parameter string R_TABLE = "r_1.dat",
   parameter int    VEC_MAX = 64,
   localparam int   SUM_W   = OUT_W + clog2(VEC_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             sum_valid,
   output logic [SUM_W-1:0] sum_data,
   output logic             sum_sat
);

   localparam int P_W = IN_W + 16;
   localparam int TF  = IN_FRAC + LOG2E_FRAC;
   localparam int I_W = P_W - TF;

   // Handshake: a beat moves when valid and ready are both high at a clock edge;
   // the whole pipe advances together whenever the output slot is free or draining.
   logic w_en;
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   // S1: clamp, scale by log2e, split into integer shift and table index
   logic signed [IN_W-1:0] w_x;
   logic signed [P_W-1:0]  w_t;
   logic signed [I_W-1:0]  w_int;
   logic        [I_W:0]    w_k_full;
   logic        [5:0]      w_k;
   logic        [R_AW-1:0] w_idx;
   logic                   w_z;

   assign w_x      = in_data[IN_W-1] ? $signed(in_data) : '0;
   assign w_t      = $signed({{16{w_x[IN_W-1]}}, w_x}) * $signed(P_W'(LOG2E_Q));
   assign w_int    = w_t[P_W-1:TF];
   assign w_k_full = -{w_int[I_W-1], w_int};
   assign w_k      = (w_k_full > (I_W+1)'(63)) ? 6'd63 : w_k_full[5:0];
   assign w_idx    = w_t[TF-1 -: R_AW];
   assign w_z      = (w_t == '0);

   logic            r_v1, r_z1, r_last1;
   logic [5:0]      r_k1;
   logic [R_AW-1:0] r_idx1;
   logic            r_v2, r_z2, r_last2;
   logic [5:0]      r_k2;
   logic [OUT_W-1:0] w_tab;

   exp2_frac_rom #(
      .R_AW    (R_AW),
      .OUT_W   (OUT_W),
      .R_TABLE (R_TABLE)
   ) u_rom (
      .clk  (clk),
      .en   (w_en),
      .addr (r_idx1),
      .data (w_tab)
   );

   // S3: scale the table value by 2^(1-k)
   logic [5:0]       w_km1;
   logic [OUT_W-1:0] w_exp;
   assign w_km1 = r_k2 - 6'd1;

   always_comb begin
      w_exp = '0;
      if (r_z2)                     w_exp = '1;
      else if (int'(w_km1) >= OUT_W) w_exp = '0;
      else                          w_exp = w_tab >> w_km1;
   end

   logic             r_v3, r_last3;
   logic [OUT_W-1:0] r_out;
   logic [SUM_W-1:0] r_acc, r_sum;
   logic             r_sat, r_sum_valid, r_sum_sat;

   logic             w_fire, w_ovf;
   logic [SUM_W:0]   w_acc_sum;
   logic [SUM_W-1:0] w_acc_sat;
   assign w_fire    = r_v3 && out_ready;
   assign w_acc_sum = {1'b0, r_acc} + (SUM_W+1)'(r_out);
   assign w_ovf     = w_acc_sum[SUM_W];
   assign w_acc_sat = w_ovf ? '1 : w_acc_sum[SUM_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0; r_z1 <= 1'b0; r_last1 <= 1'b0; r_k1 <= '0; r_idx1 <= '0;
         r_v2 <= 1'b0; r_z2 <= 1'b0; r_last2 <= 1'b0; r_k2 <= '0;
         r_v3 <= 1'b0; r_last3 <= 1'b0; r_out <= '0;
         r_acc <= '0; r_sat <= 1'b0;
         r_sum <= '0; r_sum_valid <= 1'b0; r_sum_sat <= 1'b0;
      end else begin
         r_sum_valid <= 1'b0;
         if (w_en) begin
            r_v1 <= in_valid; r_z1 <= w_z; r_last1 <= in_last; r_k1 <= w_k; r_idx1 <= w_idx;
            r_v2 <= r_v1; r_z2 <= r_z1; r_last2 <= r_last1; r_k2 <= r_k1;
            r_v3 <= r_v2; r_last3 <= r_last2; r_out <= w_exp;
         end
         if (w_fire) begin
            if (r_last3) begin
               r_sum       <= w_acc_sat;
               r_sum_valid <= 1'b1;
               r_sum_sat   <= r_sat | w_ovf;
               r_acc       <= '0;
               r_sat       <= 1'b0;
            end else begin
               r_acc <= w_acc_sat;
               r_sat <= r_sat | w_ovf;
            end
         end
      end
   end

   assign out_valid = r_v3;
   assign out_data  = r_out;
   assign out_last  = r_last3;
   assign sum_valid = r_sum_valid;
   assign sum_data  = r_sum;
   assign sum_sat   = r_sum_sat;

endmodule

// File: tb/tb_softmax_exp_stream.sv
// Bench for softmax_exp_stream: reference exp model from the arithmetic rules,
// queue scoreboard, directed corners, random streams and back-pressure.
module tb_softmax_exp_stream;

   localparam int     SUM_W   = 23;
   localparam longint SUM_MAX = (longint'(1) << SUM_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_data;
   logic              out_last;
   logic              sum_valid;
   logic [SUM_W-1:0]  sum_data;
   logic              sum_sat;

   softmax_exp_stream #(.R_TABLE("")) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .sum_valid (sum_valid),
      .sum_data  (sum_data),
      .sum_sat   (sum_sat)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [16:0] exp_q[$];
   logic [23:0] sum_q[$];
   longint      model_acc = 0;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // exp(x) from the fixed-point rules: t = x*log2e, k = -floor(t), f = frac(t)
   function automatic longint ref_exp(input logic [15:0] x);
      longint xs, t, fl, k, fr, idx, tv;
      xs = longint'($signed(x));
      if (xs > 0) xs = 0;
      t = xs * 23637;
      if (t == 0) return 65535;
      fl  = -((-t + (longint'(1) << 24) - 1) / (longint'(1) << 24));
      k   = -fl;
      if (k > 63) k = 63;
      fr  = t - fl * (longint'(1) << 24);
      idx = fr / (longint'(1) << 17);
      tv  = longint'($rtoi($pow(2.0, real'(idx) / 128.0) * 32768.0 + 0.5));
      if (k - 1 >= 16) return 0;
      return tv >> (k - 1);
   endfunction

   // Monitor
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data;
   logic        prev_last;
   int          fire_cnt = 0, first_cyc = 0, last_cyc = 0, stall_cnt = 0;
   longint      last_out = 0, last_sum = 0, last_sat = 0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_hold", out_valid, 1);
            chk("stall_data_hold", out_data, prev_data);
            chk("stall_last_hold", out_last, prev_last);
         end
         if (out_valid && !out_ready) begin
            stall_cnt++;
            chk("stall_in_ready", in_ready, 0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               chk("out_data", out_data, e[15:0]);
               chk("out_last", out_last, e[16]);
            end
            if (fire_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            fire_cnt++;
            last_out = out_data;
         end
         if (sum_valid) begin
            if (sum_q.size() == 0) begin
               chk("unexpected_sum", 1, 0);
            end else begin
               logic [23:0] s;
               s = sum_q.pop_front();
               chk("sum_data", sum_data, s[22:0]);
               chk("sum_sat", sum_sat, s[23]);
            end
            last_sum = sum_data;
            last_sat = sum_sat;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   // Random ready generator, active only when enabled
   bit rand_rdy = 1'b0;
   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input logic [15:0] x, input bit last);
      bit     ok;
      int     n;
      longint e;
      in_valid = 1'b1;
      in_data  = x;
      in_last  = last;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) begin
         chk("send_timeout", 0, 1);
      end else begin
         e = ref_exp(x);
         exp_q.push_back({last, e[15:0]});
         model_acc += e;
         if (last) begin
            sum_q.push_back({(model_acc > SUM_MAX),
                             (model_acc > SUM_MAX) ? SUM_MAX[22:0] : model_acc[22:0]});
            model_acc = 0;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || sum_q.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_x();
      return 16'(-$signed(17'($urandom_range(0, 8192))));
   endfunction

   initial begin
      int     n;
      longint ea, eb;
      logic [15:0] xa, xb;

      // Reset held two cycles with input valid
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h0000; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum_valid", sum_valid, 0);
      chk("rst_sum_data", sum_data, 0);
      chk("rst_out_data", out_data, 0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Directed single values
      send(16'h0000, 1'b1);
      n = 0;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("latency_x0", n, 3);
      drain();
      chk("exp_zero", last_out, 65535);

      send(16'hFC00, 1'b1);
      drain();
      chk("exp_m1_within_1pct", (last_out >= 23868 && last_out <= 24350), 1);

      send(16'hC000, 1'b1);
      drain();
      chk("exp_m16", last_out, 0);

      send(16'h0800, 1'b1);
      drain();
      chk("exp_pos_clamp", last_out, 65535);

      // Vector sum of four exp(0)
      for (int i = 0; i < 4; i++) send(16'h0000, i == 3);
      drain();
      chk("sum4_zero", last_sum, 262140);
      chk("sum4_sat", last_sat, 0);
      send(16'hFC00, 1'b1);
      drain();
      chk("sum_single", last_sum, ref_exp(16'hFC00));

      // 64-element back-to-back stream
      fire_cnt = 0;
      for (int i = 0; i < 64; i++) send(rand_x(), i == 63);
      drain();
      chk("stream_count", fire_cnt, 64);
      chk("stream_no_gaps", last_cyc - first_cyc, 63);

      // Back-pressure: ready low for 5 cycles mid-stream
      stall_cnt = 0;
      fork
         for (int i = 0; i < 24; i++) send(rand_x(), (i == 11) || (i == 23));
         begin
            repeat (8) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_cycles", stall_cnt, 5);

      // Random ready with random vector lengths
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) send(rand_x(), (i == 39) || ($urandom_range(0, 4) == 0));
      rand_rdy = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain();

      // Reset mid-vector discards the partial sum
      for (int i = 0; i < 3; i++) send(rand_x(), 1'b0);
      rst = 1'b1;
      exp_q.delete();
      model_acc = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      xa = rand_x();
      xb = rand_x();
      ea = ref_exp(xa);
      eb = ref_exp(xb);
      send(xa, 1'b0);
      send(xb, 1'b1);
      drain();
      chk("sum_after_reset", last_sum, ea + eb);

      chk("exp_q_empty", exp_q.size(), 0);
      chk("sum_q_empty", sum_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
